// File: rtl/qupls_free_tag_sequencer.sv
// Buffers physical-register tags released by commit and meters them out to the
// renamer's free ports in order; a flush dumps the whole backlog as one bulk mask.
module qupls_free_tag_sequencer #(
    parameter int unsigned PREGS  = 192,
    parameter int unsigned PREG_W = 8,
    parameter int unsigned IN_W   = 8,
    parameter int unsigned OUT_W  = 4,
    parameter int unsigned DEPTH  = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [IN_W-1:0]           in_valid,
    input  logic [IN_W*PREG_W-1:0]    in_tags,
    output logic                      in_ready,
    input  logic                      hold,
    input  logic                      flush,
    output logic [OUT_W*PREG_W-1:0]   tags2free,
    output logic [OUT_W-1:0]          freevals,
    output logic [PREGS-1:0]          list2free,
    output logic                      flush_done,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {RUN, FLUSH, SETTLE} state_t;

    state_t                    state, state_next;
    logic [PREG_W-1:0]         mem [DEPTH];
    logic [PTR_W-1:0]          head, tail, head_next, tail_next;
    logic [CNT_W-1:0]          cnt, cnt_next;
    logic [PTR_W-1:0]          lane_off [IN_W];
    logic [CNT_W-1:0]          push_n, pushed, pop_k;
    logic                      push_en, pop_en;
    logic [PREGS-1:0]          dump_mask;
    logic [OUT_W*PREG_W-1:0]   tags_next;
    logic [OUT_W-1:0]          fv_next;
    logic [PREGS-1:0]          list_next;
    logic                      done_next;

    assign count    = cnt;
    assign in_ready = (state == RUN) && ((CNT_W'(DEPTH) - cnt) >= CNT_W'(IN_W));

    // Compaction: each valid lane lands at tail + number of valid lanes below it.
    always_comb begin
        push_n = '0;
        for (int i = 0; i < IN_W; i++) begin
            lane_off[i] = PTR_W'(push_n);
            if (in_valid[i]) push_n = push_n + CNT_W'(1);
        end
    end

    assign push_en = in_ready && (|in_valid);
    assign pushed  = push_en ? push_n : '0;
    assign pop_en  = (state == RUN) && !hold && !flush;
    assign pop_k   = !pop_en ? '0 : ((cnt < CNT_W'(OUT_W)) ? cnt : CNT_W'(OUT_W));

    // Bulk-free mask: every occupied entry plus lanes accepted in the flush cycle.
    always_comb begin
        dump_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CNT_W'(PTR_W'(PTR_W'(i) - head)) < cnt && 32'(mem[i]) < PREGS)
                dump_mask[mem[i]] = 1'b1;
        end
        for (int i = 0; i < IN_W; i++) begin
            if (push_en && in_valid[i] && 32'(in_tags[i*PREG_W +: PREG_W]) < PREGS)
                dump_mask[in_tags[i*PREG_W +: PREG_W]] = 1'b1;
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_next = state;
        head_next  = head + PTR_W'(pop_k);
        tail_next  = tail + PTR_W'(pushed);
        cnt_next   = cnt + pushed - pop_k;
        tags_next  = '0;
        fv_next    = '0;
        list_next  = '0;
        done_next  = 1'b0;

        for (int i = 0; i < OUT_W; i++) begin
            if (CNT_W'(i) < pop_k) begin
                fv_next[i]                    = 1'b1;
                tags_next[i*PREG_W +: PREG_W] = mem[PTR_W'(head + PTR_W'(i))];
            end
        end

        case (state)
            RUN: begin
                if (flush) begin
                    state_next = FLUSH;
                    list_next  = dump_mask;
                    head_next  = tail_next;
                    cnt_next   = '0;
                end
            end
            FLUSH: begin
                state_next = SETTLE;
                done_next  = 1'b1;
            end
            SETTLE: begin
                state_next = RUN;
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    // Control state and registered renamer outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            head       <= '0;
            tail       <= '0;
            cnt        <= '0;
            tags2free  <= '0;
            freevals   <= '0;
            list2free  <= '0;
            flush_done <= 1'b0;
        end else begin
            state      <= state_next;
            head       <= head_next;
            tail       <= tail_next;
            cnt        <= cnt_next;
            tags2free  <= tags_next;
            freevals   <= fv_next;
            list2free  <= list_next;
            flush_done <= done_next;
        end
    end

    // Queue storage; contents are meaningless outside [head, head+count).
    always_ff @(posedge clk) begin
        if (!rst && push_en) begin
            for (int i = 0; i < IN_W; i++) begin
                if (in_valid[i])
                    mem[PTR_W'(tail + lane_off[i])] <= in_tags[i*PREG_W +: PREG_W];
            end
        end
    end

endmodule
